// File: rtl/dram_pkg.sv
// Shared types for the DRAM line requester: command encoding, the request word
// presented to the controller FIFO, and the requester FSM states.
package dram_pkg;

    localparam int LINE_ADDR_W = 27;
    localparam int LINE_DATA_W = 128;

    localparam logic CMD_WRITE = 1'b0;
    localparam logic CMD_READ  = 1'b1;

    typedef struct packed {
        logic [LINE_ADDR_W-1:0] addr;
        logic [LINE_DATA_W-1:0] data;
        logic                   cmd;
    } dram_req_t;

    typedef enum logic [1:0] {
        IDLE,
        WB_REQ,
        RD_REQ,
        RD_WAIT
    } req_state_t;

endpackage

// File: rtl/dram_rsp_timer.sv
// Read-response watchdog: saturating up-counter, cleared when a read is issued,
// flags expiry once it has counted TIMEOUT_CYCLES-1 waiting cycles.
module dram_rsp_timer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic sys_clk,
    input  logic sys_rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count_q;

    always_ff @(posedge sys_clk or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != LAST)) begin
            count_q <= count_q + TW'(1);
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/dram_line_requester.sv
// Initiator side of the DRAM request/response FIFO channel: services one cache miss
// at a time, writing back a dirty victim before reading the missing line.
//
//   state   | meaning
//   IDLE    | ready for a miss; captures addresses and victim data
//   WB_REQ  | write-back of the victim line offered to the controller
//   RD_REQ  | read of the missing line offered to the controller
//   RD_WAIT | read issued; waiting for data or the response timeout
module dram_line_requester
    import dram_pkg::*;
#(
    parameter int ADDR_W         = LINE_ADDR_W,
    parameter int DATA_W         = LINE_DATA_W,
    parameter int ALIGN_BITS     = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              sys_clk,
    input  logic              sys_rst_i,
    input  logic              miss_valid,
    output logic              miss_ready,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              miss_dirty,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              fill_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_err,
    output logic              fifo_req_en,
    input  logic              fifo_req_rdy,
    output logic [ADDR_W-1:0] fifo_req_addr,
    output logic [DATA_W-1:0] fifo_req_data,
    output logic              fifo_req_cmd,
    input  logic              fifo_rsp_en,
    input  logic [DATA_W-1:0] fifo_rsp_data,
    output logic              stray_rsp
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << ALIGN_BITS) - 1);

    req_state_t        state_q, state_d;
    dram_req_t         req_q, req_d;
    logic              req_en_q, req_en_d;
    logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
    logic              fill_valid_q, fill_valid_d;
    logic              fill_err_q, fill_err_d;
    logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
    logic [DATA_W-1:0] fill_data_q, fill_data_d;
    logic              stray_q, stray_d;
    logic              timer_clear, timer_en, timer_expired;

    dram_rsp_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rsp_timer (
        .sys_clk  (sys_clk),
        .sys_rst_i(sys_rst_i),
        .clear    (timer_clear),
        .enable   (timer_en),
        .expired  (timer_expired)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_q      <= IDLE;
            req_q        <= '0;
            req_en_q     <= 1'b0;
            miss_addr_q  <= '0;
            fill_valid_q <= 1'b0;
            fill_err_q   <= 1'b0;
            fill_addr_q  <= '0;
            fill_data_q  <= '0;
            stray_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            req_en_q     <= req_en_d;
            miss_addr_q  <= miss_addr_d;
            fill_valid_q <= fill_valid_d;
            fill_err_q   <= fill_err_d;
            fill_addr_q  <= fill_addr_d;
            fill_data_q  <= fill_data_d;
            stray_q      <= stray_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        req_en_d     = req_en_q;
        miss_addr_d  = miss_addr_q;
        fill_valid_d = 1'b0;
        fill_err_d   = 1'b0;
        fill_addr_d  = fill_addr_q;
        fill_data_d  = fill_data_q;
        timer_clear  = 1'b0;
        timer_en     = 1'b0;
        // Any response we are not waiting for is dropped, but remembered.
        stray_d      = stray_q | (fifo_rsp_en && (state_q != RD_WAIT));

        case (state_q)
            IDLE: begin
                if (miss_valid) begin
                    miss_addr_d = miss_addr & ALIGN_MASK;
                    req_en_d    = 1'b1;
                    if (miss_dirty) begin
                        req_d   = '{addr: wb_addr & ALIGN_MASK, data: wb_data, cmd: CMD_WRITE};
                        state_d = WB_REQ;
                    end else begin
                        req_d   = '{addr: miss_addr & ALIGN_MASK, data: wb_data, cmd: CMD_READ};
                        state_d = RD_REQ;
                    end
                end
            end
            WB_REQ: begin
                if (fifo_req_rdy) begin
                    req_d.addr = miss_addr_q;
                    req_d.cmd  = CMD_READ;
                    state_d    = RD_REQ;
                end
            end
            RD_REQ: begin
                if (fifo_req_rdy) begin
                    req_en_d    = 1'b0;
                    timer_clear = 1'b1;
                    state_d     = RD_WAIT;
                end
            end
            RD_WAIT: begin
                timer_en = 1'b1;
                if (fifo_rsp_en) begin
                    fill_valid_d = 1'b1;
                    fill_addr_d  = miss_addr_q;
                    fill_data_d  = fifo_rsp_data;
                    state_d      = IDLE;
                end else if (timer_expired) begin
                    fill_valid_d = 1'b1;
                    fill_err_d   = 1'b1;
                    fill_addr_d  = miss_addr_q;
                    fill_data_d  = '0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign miss_ready    = (state_q == IDLE);
    assign fifo_req_en   = req_en_q;
    assign fifo_req_addr = req_q.addr;
    assign fifo_req_data = req_q.data;
    assign fifo_req_cmd  = req_q.cmd;
    assign fill_valid    = fill_valid_q;
    assign fill_err      = fill_err_q;
    assign fill_addr     = fill_addr_q;
    assign fill_data     = fill_data_q;
    assign stray_rsp     = stray_q;

endmodule

// File: tb/tb_dram_line_requester.sv
// Bench for dram_line_requester: directed scenarios plus randomized misses checked
// against a transaction-level model of the expected requests and fills.
module tb_dram_line_requester;
    import dram_pkg::*;

    localparam int AW = 27;
    localparam int DW = 128;
    localparam int TO = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst_i = 1'b1;
    logic          miss_valid = 1'b0;
    logic          miss_ready;
    logic [AW-1:0] miss_addr = '0;
    logic          miss_dirty = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic [DW-1:0] wb_data = '0;
    logic          fill_valid;
    logic [AW-1:0] fill_addr;
    logic [DW-1:0] fill_data;
    logic          fill_err;
    logic          fifo_req_en;
    logic          fifo_req_rdy = 1'b0;
    logic [AW-1:0] fifo_req_addr;
    logic [DW-1:0] fifo_req_data;
    logic          fifo_req_cmd;
    logic          fifo_rsp_en = 1'b0;
    logic [DW-1:0] fifo_rsp_data = '0;
    logic          stray_rsp;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    dram_line_requester #(
        .ADDR_W(AW), .DATA_W(DW), .ALIGN_BITS(3), .TIMEOUT_CYCLES(TO)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_i(sys_rst_i),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .miss_dirty(miss_dirty), .wb_addr(wb_addr), .wb_data(wb_data),
        .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data), .fill_err(fill_err),
        .fifo_req_en(fifo_req_en), .fifo_req_rdy(fifo_req_rdy), .fifo_req_addr(fifo_req_addr),
        .fifo_req_data(fifo_req_data), .fifo_req_cmd(fifo_req_cmd),
        .fifo_rsp_en(fifo_rsp_en), .fifo_rsp_data(fifo_rsp_data), .stray_rsp(stray_rsp)
    );

    // Observed channel traffic; edge numbers are the clock edge the event happened on.
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic cmd; int cyc; } req_rec_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic err; int cyc; } fill_rec_t;
    req_rec_t  req_log[$];
    fill_rec_t fill_log[$];

    always @(negedge sys_clk) begin
        if (sys_rst_i && fifo_req_en && fifo_req_rdy)
            req_log.push_back('{addr: fifo_req_addr, data: fifo_req_data, cmd: fifo_req_cmd, cyc: cyc + 1});
        if (fill_valid)
            fill_log.push_back('{addr: fill_addr, data: fill_data, err: fill_err, cyc: cyc});
    end

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return (a >> 3) << 3;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic apply_reset();
        miss_valid = 1'b0; fifo_req_rdy = 1'b0; fifo_rsp_en = 1'b0;
        sys_rst_i = 1'b0;
        tick(); tick();
        sys_rst_i = 1'b1;
        tick();
        req_log.delete(); fill_log.delete();
    endtask

    // Offers one miss, handshakes its requests, optionally answers the read rsp_dly
    // edges after the read handshake (0 = never). h returns the read handshake edge.
    task automatic run_miss(input logic [AW-1:0] a, input logic dirty, input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd, input int stall, input int rsp_dly,
                            input logic [DW-1:0] rd, output int h);
        int g, hs, need;
        h = -1; hs = 0; need = dirty ? 2 : 1;
        g = 0;
        while (!miss_ready && g < 100) begin tick(); g++; end
        miss_valid = 1'b1; miss_addr = a; miss_dirty = dirty; wb_addr = wa; wb_data = wd;
        fifo_req_rdy = 1'b0;
        tick();
        miss_valid = 1'b0; miss_addr = AW'($urandom); miss_dirty = 1'b0;
        wb_addr = AW'($urandom); wb_data = {$urandom, $urandom, $urandom, $urandom};
        g = 0;
        while (h < 0 && g < 200) begin
            fifo_req_rdy = (stall == 0) ? 1'b1 : ($urandom_range(0, stall) == 0);
            if (fifo_req_en && fifo_req_rdy) begin
                hs++;
                if (hs == need) h = cyc + 1;
            end
            tick(); g++;
        end
        fifo_req_rdy = 1'b0;
        if (h >= 0 && rsp_dly > 0) begin
            repeat (rsp_dly - 1) tick();
            fifo_rsp_en = 1'b1; fifo_rsp_data = rd;
            tick();
            fifo_rsp_en = 1'b0; fifo_rsp_data = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic wait_fills(input int n);
        int g = 0;
        while (fill_log.size() < n && g < 60) begin tick(); g++; end
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({fifo_req_en, fill_valid, fill_err, stray_rsp, fifo_req_cmd} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags: got en/fv/fe/stray/cmd=%b, need 00000",
                              {fifo_req_en, fill_valid, fill_err, stray_rsp, fifo_req_cmd});
        end
        n_cmp++;
        if ({fill_addr, fill_data, fifo_req_addr, fifo_req_data} !== '0) begin
            n_bad++; $display("FAIL reset_data: got fill_addr=%h fill_data=%h req_addr=%h req_data=%h, need all 0",
                              fill_addr, fill_data, fifo_req_addr, fifo_req_data);
        end
        n_cmp++;
        if (miss_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready: got miss_ready=%b, need 1", miss_ready);
        end
    endtask

    task automatic test_clean_miss();
        int h;
        logic [DW-1:0] rd;
        apply_reset();
        rd = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
        run_miss(27'h0001235, 1'b0, 27'h0000055, '1, 0, 3, rd, h);
        wait_fills(1);
        repeat (3) tick();
        n_cmp++;
        if (req_log.size() != 1 || req_log[0].addr !== 27'h0001230 || req_log[0].cmd !== CMD_READ) begin
            n_bad++; $display("FAIL clean_req: got %0d requests first addr=%h cmd=%b, need 1 request addr=0001230 cmd=1",
                              req_log.size(), req_log[0].addr, req_log[0].cmd);
        end
        n_cmp++;
        if (fill_log.size() != 1 || {fill_log[0].addr, fill_log[0].data, fill_log[0].err} !== {27'h0001230, rd, 1'b0}) begin
            n_bad++; $display("FAIL clean_fill: got %0d fills addr=%h data=%h err=%b, need 1 fill addr=0001230 data=%h err=0",
                              fill_log.size(), fill_log[0].addr, fill_log[0].data, fill_log[0].err, rd);
        end
        n_cmp++;
        if (fill_log[0].cyc != h + 3) begin
            n_bad++; $display("FAIL clean_latency: got fill at edge %0d, need %0d", fill_log[0].cyc, h + 3);
        end
    endtask

    task automatic test_dirty_miss();
        logic [DW-1:0] wd, rd;
        int h;
        apply_reset();
        wd = {32{4'h1}};
        rd = {$urandom, $urandom, $urandom, $urandom};
        miss_valid = 1'b1; miss_addr = 27'h0000F0F; miss_dirty = 1'b1; wb_addr = 27'h00A0008; wb_data = wd;
        fifo_req_rdy = 1'b0;
        tick();
        miss_valid = 1'b0; miss_addr = '0; miss_dirty = 1'b0; wb_addr = '0; wb_data = '0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({fifo_req_en, fifo_req_cmd, fifo_req_addr, fifo_req_data} !== {1'b1, CMD_WRITE, 27'h00A0008, wd}) begin
                n_bad++; $display("FAIL dirty_hold[%0d]: got en=%b cmd=%b addr=%h data=%h, need en=1 cmd=0 addr=00a0008 data=%h",
                                  i, fifo_req_en, fifo_req_cmd, fifo_req_addr, fifo_req_data, wd);
            end
            tick();
        end
        fifo_req_rdy = 1'b1;
        tick();
        n_cmp++;
        if ({fifo_req_en, fifo_req_cmd, fifo_req_addr} !== {1'b1, CMD_READ, 27'h0000F08}) begin
            n_bad++; $display("FAIL dirty_read_offer: got en=%b cmd=%b addr=%h, need en=1 cmd=1 addr=0000f08",
                              fifo_req_en, fifo_req_cmd, fifo_req_addr);
        end
        tick();
        h = cyc;
        fifo_req_rdy = 1'b0;
        n_cmp++;
        if (fifo_req_en !== 1'b0) begin
            n_bad++; $display("FAIL dirty_req_drop: got fifo_req_en=%b in wait, need 0", fifo_req_en);
        end
        tick();
        fifo_rsp_en = 1'b1; fifo_rsp_data = rd;
        tick();
        fifo_rsp_en = 1'b0;
        wait_fills(1);
        n_cmp++;
        if (req_log.size() != 2 || {req_log[0].addr, req_log[0].data, req_log[0].cmd} !== {27'h00A0008, wd, CMD_WRITE}
            || {req_log[1].addr, req_log[1].cmd} !== {27'h0000F08, CMD_READ} || req_log[1].cyc != req_log[0].cyc + 1) begin
            n_bad++; $display("FAIL dirty_order: got %0d requests cmd0=%b addr0=%h cmd1=%b addr1=%h, need write 00a0008 then read 0000f08 back to back",
                              req_log.size(), req_log[0].cmd, req_log[0].addr, req_log[1].cmd, req_log[1].addr);
        end
        n_cmp++;
        if (fill_log.size() != 1 || {fill_log[0].addr, fill_log[0].data, fill_log[0].err} !== {27'h0000F08, rd, 1'b0}
            || fill_log[0].cyc != h + 2) begin
            n_bad++; $display("FAIL dirty_fill: got addr=%h data=%h err=%b edge=%0d, need addr=0000f08 data=%h err=0 edge=%0d",
                              fill_log[0].addr, fill_log[0].data, fill_log[0].err, fill_log[0].cyc, rd, h + 2);
        end
    endtask

    task automatic test_timeout();
        int h;
        apply_reset();
        run_miss(27'h0123457, 1'b0, '0, '0, 0, 0, '0, h);
        wait_fills(1);
        n_cmp++;
        if (fill_log.size() != 1 || {fill_log[0].addr, fill_log[0].data, fill_log[0].err} !== {27'h0123450, 128'h0, 1'b1}
            || fill_log[0].cyc != h + TO) begin
            n_bad++; $display("FAIL timeout_fill: got addr=%h data=%h err=%b edge=%0d, need addr=0123450 data=0 err=1 edge=%0d",
                              fill_log[0].addr, fill_log[0].data, fill_log[0].err, fill_log[0].cyc, h + TO);
        end
        n_cmp++;
        if (stray_rsp !== 1'b0) begin
            n_bad++; $display("FAIL timeout_no_stray_yet: got stray_rsp=%b, need 0", stray_rsp);
        end
        while (cyc < h + 19) tick();
        fifo_rsp_en = 1'b1; fifo_rsp_data = '1;
        tick();
        fifo_rsp_en = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (stray_rsp !== 1'b1 || fill_log.size() != 1) begin
            n_bad++; $display("FAIL late_rsp: got stray_rsp=%b fills=%0d, need stray_rsp=1 fills=1", stray_rsp, fill_log.size());
        end
    endtask

    task automatic test_rsp_at_expiry();
        int h;
        logic [DW-1:0] rd;
        apply_reset();
        rd = {$urandom, $urandom, $urandom, $urandom};
        run_miss(27'h0400009, 1'b0, '0, '0, 2, TO, rd, h);
        wait_fills(1);
        tick();
        n_cmp++;
        if (fill_log.size() != 1 || {fill_log[0].addr, fill_log[0].data, fill_log[0].err} !== {27'h0400008, rd, 1'b0}
            || fill_log[0].cyc != h + TO || stray_rsp !== 1'b0) begin
            n_bad++; $display("FAIL rsp_at_expiry: got fills=%0d addr=%h data=%h err=%b edge=%0d stray=%b, need addr=0400008 data=%h err=0 edge=%0d stray=0",
                              fill_log.size(), fill_log[0].addr, fill_log[0].data, fill_log[0].err, fill_log[0].cyc, stray_rsp, rd, h + TO);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a1, a2;
        logic [DW-1:0] d1, d2;
        apply_reset();
        a1 = 27'h1234567; a2 = 27'h0ABCDEF;
        d1 = {$urandom, $urandom, $urandom, $urandom};
        d2 = {$urandom, $urandom, $urandom, $urandom};
        miss_valid = 1'b1; miss_addr = a1; miss_dirty = 1'b0; fifo_req_rdy = 1'b1;
        tick();
        miss_addr = a2;
        n_cmp++;
        if (miss_ready !== 1'b0) begin
            n_bad++; $display("FAIL b2b_busy_req: got miss_ready=%b, need 0", miss_ready);
        end
        tick();
        fifo_req_rdy = 1'b0;
        n_cmp++;
        if ({miss_ready, fifo_req_en} !== 2'b00) begin
            n_bad++; $display("FAIL b2b_busy_wait: got miss_ready=%b req_en=%b, need 0 0", miss_ready, fifo_req_en);
        end
        fifo_rsp_en = 1'b1; fifo_rsp_data = d1;
        tick();
        fifo_rsp_en = 1'b0;
        n_cmp++;
        if ({fill_valid, miss_ready, fill_addr, fill_data, fill_err} !== {1'b1, 1'b1, align(a1), d1, 1'b0}) begin
            n_bad++; $display("FAIL b2b_fill1: got fv=%b ready=%b addr=%h data=%h err=%b, need 1 1 %h %h 0",
                              fill_valid, miss_ready, fill_addr, fill_data, fill_err, align(a1), d1);
        end
        fifo_req_rdy = 1'b1;
        tick();
        n_cmp++;
        if ({miss_ready, fill_valid, fifo_req_en, fifo_req_cmd, fifo_req_addr} !== {1'b0, 1'b0, 1'b1, CMD_READ, align(a2)}) begin
            n_bad++; $display("FAIL b2b_accept2: got ready=%b fv=%b en=%b cmd=%b addr=%h, need 0 0 1 1 %h",
                              miss_ready, fill_valid, fifo_req_en, fifo_req_cmd, fifo_req_addr, align(a2));
        end
        miss_valid = 1'b0;
        tick();
        fifo_req_rdy = 1'b0;
        fifo_rsp_en = 1'b1; fifo_rsp_data = d2;
        tick();
        fifo_rsp_en = 1'b0;
        wait_fills(2);
        n_cmp++;
        if (fill_log.size() != 2 || {fill_log[1].addr, fill_log[1].data, fill_log[1].err} !== {align(a2), d2, 1'b0}) begin
            n_bad++; $display("FAIL b2b_fill2: got fills=%0d addr=%h data=%h err=%b, need 2 fills, last addr=%h data=%h err=0",
                              fill_log.size(), fill_log[1].addr, fill_log[1].data, fill_log[1].err, align(a2), d2);
        end
    endtask

    task automatic test_async_reset();
        int h, nf;
        apply_reset();
        run_miss(27'h0054321, 1'b1, 27'h0077777, '1, 0, 2, '1, h);
        wait_fills(1);
        miss_valid = 1'b1; miss_addr = 27'h0000ABC; miss_dirty = 1'b0; fifo_req_rdy = 1'b1;
        tick();
        miss_valid = 1'b0;
        tick();
        fifo_req_rdy = 1'b0;
        tick(); tick();
        nf = fill_log.size();
        #3;
        sys_rst_i = 1'b0;
        #1;
        n_cmp++;
        if ({fifo_req_en, fill_valid, fill_err, stray_rsp, fifo_req_cmd, fill_addr, fill_data, fifo_req_addr, fifo_req_data} !== '0
            || miss_ready !== 1'b1) begin
            n_bad++; $display("FAIL async_reset: got en=%b fv=%b fe=%b stray=%b cmd=%b fill_addr=%h req_addr=%h ready=%b, need all 0 and ready=1",
                              fifo_req_en, fill_valid, fill_err, stray_rsp, fifo_req_cmd, fill_addr, fifo_req_addr, miss_ready);
        end
        tick();
        sys_rst_i = 1'b1;
        tick();
        fifo_rsp_en = 1'b1; fifo_rsp_data = '1;
        tick();
        fifo_rsp_en = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (stray_rsp !== 1'b1 || fill_log.size() != nf) begin
            n_bad++; $display("FAIL post_reset_rsp: got stray_rsp=%b fills=%0d, need stray_rsp=1 fills=%0d",
                              stray_rsp, fill_log.size(), nf);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a, wa, ea;
        logic [DW-1:0] wd, rd, ed;
        logic dirty, ee, exp_stray;
        int stall, dly, h, ec, need;
        apply_reset();
        exp_stray = 1'b0;
        for (int t = 0; t < 30; t++) begin
            a = AW'($urandom); wa = AW'($urandom);
            wd = {$urandom, $urandom, $urandom, $urandom};
            rd = {$urandom, $urandom, $urandom, $urandom};
            dirty = 1'($urandom_range(0, 1));
            stall = $urandom_range(0, 3);
            dly = $urandom_range(0, TO + 3);
            req_log.delete(); fill_log.delete();
            run_miss(a, dirty, wa, wd, stall, dly, rd, h);
            wait_fills(1);
            tick(); tick();
            // Model: a response within TO edges of the read wins, otherwise a timeout fill.
            need = dirty ? 2 : 1;
            ea = align(a);
            if (dly >= 1 && dly <= TO) begin ed = rd; ee = 1'b0; ec = h + dly; end
            else begin ed = '0; ee = 1'b1; ec = h + TO; end
            if (dly > TO) exp_stray = 1'b1;
            n_cmp++;
            if (req_log.size() != need || {req_log[need-1].addr, req_log[need-1].cmd} !== {ea, CMD_READ}
                || (dirty && {req_log[0].addr, req_log[0].data, req_log[0].cmd} !== {align(wa), wd, CMD_WRITE})) begin
                n_bad++; $display("FAIL rand_req[%0d]: got %0d requests last addr=%h cmd=%b, need %0d requests ending in read of %h",
                                  t, req_log.size(), req_log[req_log.size()-1].addr, req_log[req_log.size()-1].cmd, need, ea);
            end
            n_cmp++;
            if (fill_log.size() != 1 || {fill_log[0].addr, fill_log[0].data, fill_log[0].err} !== {ea, ed, ee}
                || fill_log[0].cyc != ec) begin
                n_bad++; $display("FAIL rand_fill[%0d]: got fills=%0d addr=%h data=%h err=%b edge=%0d, need 1 fill addr=%h data=%h err=%b edge=%0d",
                                  t, fill_log.size(), fill_log[0].addr, fill_log[0].data, fill_log[0].err, fill_log[0].cyc, ea, ed, ee, ec);
            end
        end
        n_cmp++;
        if (stray_rsp !== exp_stray) begin
            n_bad++; $display("FAIL rand_stray: got stray_rsp=%b, need %b", stray_rsp, exp_stray);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_timeout();
        test_rsp_at_expiry();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
